// File: rtl/ppc_gpr_file.sv
// General-purpose register file: 32 x 64-bit, two registered read ports and
// two write ports. Reads are read-before-write; port 1 wins a same-address write.
module ppc_gpr_file #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en0,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [0:DATA_W-1] rd_data0,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [0:DATA_W-1] rd_data1,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [0:DATA_W-1] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [0:DATA_W-1] wr_data1
);

  logic [0:DATA_W-1] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs     <= '{default: '0};
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      // Reads sample the pre-edge contents, so a same-edge write is not bypassed.
      if (rd_en0) rd_data0 <= regs[rd_addr0];
      if (rd_en1) rd_data1 <= regs[rd_addr1];
      // Port 1 is written last so it takes priority on an address collision.
      if (wr_en0) regs[wr_addr0] <= wr_data0;
      if (wr_en1) regs[wr_addr1] <= wr_data1;
    end
  end

endmodule

// File: tb/tb_ppc_gpr_file.sv
// Self-checking bench for ppc_gpr_file: directed vector table plus randomized
// traffic compared against an array-based reference model.
module tb_ppc_gpr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en0, rd_en1, wr_en0, wr_en1;
  logic [4:0]  rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [63:0] wr_data0, wr_data1;
  logic [63:0] rd_data0, rd_data1;

  int nChecks = 0;
  int nPass   = 0;

  // Reference state: register contents and the two read-port holding values.
  logic [63:0] mem [32];
  logic [63:0] m0, m1;

  always #5 clk = ~clk;

  ppc_gpr_file #(.DATA_W(64), .ADDR_W(5), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(rd_data0),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1)
  );

  typedef struct {
    bit          rst;       // 1 = assert reset this cycle
    bit          re0;
    logic [4:0]  ra0;
    bit          re1;
    logic [4:0]  ra1;
    bit          we0;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    bit          we1;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    bit          c0;
    logic [63:0] e0;
    bit          c1;
    logic [63:0] e1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit re0, logic [4:0] ra0, bit re1, logic [4:0] ra1,
                              bit we0, logic [4:0] wa0, logic [63:0] wd0,
                              bit we1, logic [4:0] wa1, logic [63:0] wd1,
                              bit c0, logic [63:0] e0, bit c1, logic [63:0] e1);
    vec_t v;
    v.rst = rst; v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0; v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.c0 = c0; v.e0 = e0; v.c1 = c1; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive, take the edge, advance the model, settle.
  task automatic step(input bit rst, input bit re0, input logic [4:0] ra0,
                      input bit re1, input logic [4:0] ra1,
                      input bit we0, input logic [4:0] wa0, input logic [63:0] wd0,
                      input bit we1, input logic [4:0] wa1, input logic [63:0] wd1);
    rst_n = ~rst;
    rd_en0 = re0; rd_addr0 = ra0; rd_en1 = re1; rd_addr1 = ra1;
    wr_en0 = we0; wr_addr0 = wa0; wr_data0 = wd0;
    wr_en1 = we1; wr_addr1 = wa1; wr_data1 = wd1;
    @(posedge clk);
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
      m0 = '0;
      m1 = '0;
    end else begin
      if (re0) m0 = mem[ra0];
      if (re1) m1 = mem[ra1];
      if (we0) mem[wa0] = wd0;
      if (we1) mem[wa1] = wd1;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    m0 = '0;
    m1 = '0;

    // Reset for two edges, then sweep every register on both ports.
    step(1, 0, 0, 0, 0, 1, 4, 64'hDEAD, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
    check("rst_rd0", rd_data0, 64'h0);
    check("rst_rd1", rd_data1, 64'h0);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 5'(i), 1, 5'(31 - i), 0, 0, '0, 0, 0, '0);
      check($sformatf("rst_sweep0_r%0d", i), rd_data0, 64'h0);
      check($sformatf("rst_sweep1_r%0d", 31 - i), rd_data1, 64'h0);
    end

    // Directed table: each row is one cycle; expectations are post-edge outputs.
    tbl.push_back(mk(0, 0,0, 0,0, 1,5,64'h0123456789ABCDEF, 0,0,0, 1,0, 1,0));
    tbl.push_back(mk(0, 1,5, 1,5, 0,0,0, 0,0,0, 1,64'h0123456789ABCDEF, 1,64'h0123456789ABCDEF));
    tbl.push_back(mk(0, 0,0, 0,0, 1,5,64'hFFFFFFFFFFFFFFFF, 0,0,0, 1,64'h0123456789ABCDEF, 0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 1,5,64'hFFFFFFFFFFFFFFFF, 0,0,0, 1,64'h0123456789ABCDEF, 0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 1,5,64'hFFFFFFFFFFFFFFFF, 0,0,0, 1,64'h0123456789ABCDEF, 1,64'h0123456789ABCDEF));
    tbl.push_back(mk(0, 1,5, 0,0, 0,0,0, 0,0,0, 1,64'hFFFFFFFFFFFFFFFF, 1,64'h0123456789ABCDEF));
    tbl.push_back(mk(0, 0,0, 0,0, 1,7,64'h10, 1,8,64'h2000, 1,64'hFFFFFFFFFFFFFFFF, 0,0));
    tbl.push_back(mk(0, 1,7, 1,8, 0,0,0, 0,0,0, 1,64'h10, 1,64'h2000));
    tbl.push_back(mk(0, 0,0, 0,0, 1,9,64'hAAAA, 1,9,64'h5555, 1,64'h10, 1,64'h2000));
    tbl.push_back(mk(0, 1,9, 1,9, 0,0,0, 0,0,0, 1,64'h5555, 1,64'h5555));
    tbl.push_back(mk(0, 0,0, 0,0, 1,3,64'h1, 0,0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,3, 1,3, 1,3,64'h2, 0,0,0, 1,64'h1, 1,64'h1));
    tbl.push_back(mk(0, 1,3, 0,0, 0,0,0, 0,0,0, 1,64'h2, 1,64'h1));
    tbl.push_back(mk(0, 1,0, 1,0, 0,0,0, 0,0,0, 1,64'h0, 1,64'h0));
    tbl.push_back(mk(1, 1,3, 1,3, 1,3,64'h7, 0,0,0, 1,64'h0, 1,64'h0));
    tbl.push_back(mk(0, 1,3, 1,9, 0,0,0, 0,0,0, 1,64'h0, 1,64'h0));
    tbl.push_back(mk(0, 1,5, 1,8, 0,0,0, 0,0,0, 1,64'h0, 1,64'h0));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].re0, tbl[k].ra0, tbl[k].re1, tbl[k].ra1,
           tbl[k].we0, tbl[k].wa0, tbl[k].wd0, tbl[k].we1, tbl[k].wa1, tbl[k].wd1);
      if (tbl[k].c0) check($sformatf("vec%0d_rd0", k), rd_data0, tbl[k].e0);
      if (tbl[k].c1) check($sformatf("vec%0d_rd1", k), rd_data1, tbl[k].e1);
    end

    // Long hold: rd_en low while other registers churn.
    step(0, 1, 8, 1, 7, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 8, 64'h8888, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 7, 64'h7777, 1, 8, 64'h9999);
    for (int i = 0; i < 6; i++) idle();
    check("long_hold_rd0", rd_data0, 64'h0);
    check("long_hold_rd1", rd_data1, 64'h0);
    step(0, 1, 8, 1, 7, 0, 0, '0, 0, 0, '0);
    check("after_hold_rd0", rd_data0, 64'h9999);
    check("after_hold_rd1", rd_data1, 64'h7777);

    // Randomized traffic, addresses often confined to a small window to force collisions.
    for (int n = 0; n < 600; n++) begin
      bit narrow;
      logic [4:0] msk;
      narrow = ($urandom_range(0, 1) == 1);
      msk = narrow ? 5'h3 : 5'h1F;
      step(($urandom_range(0, 79) == 0),
           bit'($urandom_range(0, 1)), 5'($urandom) & msk,
           bit'($urandom_range(0, 1)), 5'($urandom) & msk,
           bit'($urandom_range(0, 1)), 5'($urandom) & msk, {$urandom, $urandom},
           bit'($urandom_range(0, 1)), 5'($urandom) & msk, {$urandom, $urandom});
      check($sformatf("rand%0d_rd0", n), rd_data0, m0);
      check($sformatf("rand%0d_rd1", n), rd_data1, m1);
    end

    // Final sweep of the whole file against the model.
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 5'(i), 1, 5'(i ^ 31), 0, 0, '0, 0, 0, '0);
      check($sformatf("final0_r%0d", i), rd_data0, m0);
      check($sformatf("final1_r%0d", i ^ 31), rd_data1, m1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
